// File: rtl/inst_prefetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer.
// Provides bus widths, the NOP encoding, the default prefetch depth,
// the {addr,inst} entry type held by the data FIFO and a word-align helper.
package inst_prefetch_buf_pkg;

  localparam int unsigned INST_DATA_BUS  = 32;
  localparam int unsigned INST_ADDR_BUS  = 32;
  localparam int unsigned PREFETCH_DEPTH = 4;

  typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
  typedef logic [INST_DATA_BUS-1:0] inst_data_t;

  localparam inst_data_t INST_NOP = 32'h0000_0013;

  // One buffered fetch result as presented at the fetch/decode boundary
  typedef struct packed {
    inst_addr_t addr;
    inst_data_t inst;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned
  function automatic inst_addr_t align_word(input inst_addr_t a);
    return a & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/inst_prefetch_buf_if.sv
// Bus bundle of the instruction prefetch buffer.
// Carries the instruction-memory request/response channel and the
// valid/ready delivery channel towards the fetch/decode boundary.
//   master : the prefetch buffer (drives mem_req/mem_addr and ins_*)
//   slave  : the environment (memory and consumer)
interface inst_prefetch_buf_if;
  import inst_prefetch_buf_pkg::*;

  logic       mem_req_o;
  inst_addr_t mem_addr_o;
  logic       mem_gnt_i;
  logic       mem_rvalid_i;
  inst_data_t mem_rdata_i;

  logic       ins_valid_o;
  inst_data_t ins_o;
  inst_addr_t ins_addr_o;
  logic       ins_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i
  );

endinterface

// File: rtl/inst_prefetch_buf_sync_fifo.sv
// Synchronous FIFO with flush, used for both the data and issued-address queues.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   flush         empty the FIFO on the next edge; wins over push/pop
//   rdata         head entry (undefined content when empty)
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
module inst_prefetch_buf_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr];
  assign count   = cnt;

  // Storage array; no reset needed since empty masks stale content
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch stage upstream of the pc/if_id pair.
// Issues sequential word fetches, buffers returned {addr,inst} pairs and
// presents them with valid/ready; a jump redirects and drops stale returns.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   jump_flag_i   redirect request from the execute stage
//   jump_addr_i   redirect target (byte offset ignored)
//   bus           memory request/response and instruction delivery bundle
module inst_prefetch_buf
  import inst_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = PREFETCH_DEPTH,
  parameter inst_addr_t  RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_flag_i,
  input  inst_addr_t          jump_addr_i,
  inst_prefetch_buf_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  inst_addr_t       fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;

  logic [CNT_W-1:0] data_count;
  logic             data_full;
  logic             data_empty;
  logic [ENT_W-1:0] data_rdata;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  logic [CNT_W-1:0] addr_count;
  logic             addr_full;
  logic             addr_empty;
  inst_addr_t       addr_head;

  logic credit_ok;
  logic req;
  logic issue;
  logic rsp;
  logic rsp_drop;
  logic rsp_keep;
  logic pop;

  // Credit check: buffered plus in-flight words must leave room for one more
  assign credit_ok = (SUM_W'(data_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
  assign req       = !rst && !jump_flag_i && credit_ok && !addr_full;
  assign issue     = req && bus.mem_gnt_i;

  // A return with nothing outstanding is a protocol error and is ignored
  assign rsp      = bus.mem_rvalid_i && (outstanding != '0);
  assign rsp_drop = rsp && (discard != '0);
  assign rsp_keep = rsp && (discard == '0) && !jump_flag_i && !addr_empty && !data_full;
  assign pop      = !data_empty && bus.ins_ready_i && !jump_flag_i;

  assign push_entry = '{addr: addr_head, inst: bus.mem_rdata_i};
  assign head       = fetch_entry_t'(data_rdata);

  assign bus.mem_req_o   = req;
  assign bus.mem_addr_o  = fetch_pc;
  assign bus.ins_valid_o = !data_empty;
  assign bus.ins_o       = data_empty ? INST_NOP : head.inst;
  assign bus.ins_addr_o  = data_empty ? '0 : head.addr;

  // Delivered {addr,inst} queue
  inst_prefetch_buf_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (pop),
    .flush (jump_flag_i),
    .wdata (ENT_W'(push_entry)),
    .rdata (data_rdata),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  // Addresses of issued requests whose data will be kept; dropped
  // returns never reach it because a jump flushes it
  inst_prefetch_buf_sync_fifo #(
    .WIDTH (INST_ADDR_BUS),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (rsp_keep),
    .flush (jump_flag_i),
    .wdata (fetch_pc),
    .rdata (addr_head),
    .full  (addr_full),
    .empty (addr_empty),
    .count (addr_count)
  );

  // Fetch pointer and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= align_word(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp);
      if (jump_flag_i) begin
        // Everything still in flight after this cycle's return is stale
        fetch_pc <= align_word(jump_addr_i);
        discard  <= outstanding - CNT_W'(rsp);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_drop) begin
          discard <= discard - CNT_W'(1);
        end
      end
    end
  end

  // Kept in-flight requests are exactly the ones with a queued address
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (SUM_W'(addr_count) + SUM_W'(discard) == SUM_W'(outstanding));
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Self-checking bench for inst_prefetch_buf: random memory/consumer/jump/reset
// stimulus compared every cycle against a queue-based reference model.
module tb_inst_prefetch_buf;
  import inst_prefetch_buf_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] addr; bit stale; }        flight_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;

  inst_prefetch_buf_if bus_if ();

  inst_prefetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag),
    .jump_addr_i (jump_addr),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  pend_t       pend_q[$];
  flight_t     flight_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  int unsigned cyc;
  int          n_cmp;
  int          n_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_jaddr();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      2:       return 32'h0000_0100;
      default: return 32'h0000_0202;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model
  task automatic step(input bit r, input bit j, input logic [31:0] ja,
                      input bit g, input bit rdy, input int unsigned dly);
    bit      exp_req;
    bit      issue;
    bit      rv;
    bit      jmp;
    flight_t f;
    @(negedge clk);
    cyc++;
    if (!r && rst) pend_q.delete();
    jmp = j && !r;
    rst                 = r;
    jump_flag           = jmp;
    jump_addr           = ja;
    bus_if.mem_gnt_i    = g;
    bus_if.ins_ready_i  = rdy;
    rv                  = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    bus_if.mem_rvalid_i = rv;
    bus_if.mem_rdata_i  = rv ? mem_word(pend_q[0].addr) : $urandom;
    #1;
    exp_req = !r && !jmp && ((fifo_q.size() + flight_q.size()) < DEPTH);
    check("mem_req",   32'(bus_if.mem_req_o),   32'(exp_req));
    check("mem_addr",  bus_if.mem_addr_o,       m_pc);
    check("ins_valid", 32'(bus_if.ins_valid_o), 32'(fifo_q.size() > 0));
    check("ins",       bus_if.ins_o,      (fifo_q.size() > 0) ? fifo_q[0].inst : INST_NOP);
    check("ins_addr",  bus_if.ins_addr_o, (fifo_q.size() > 0) ? fifo_q[0].addr : 32'h0);

    issue = exp_req && g;
    if (rv) void'(pend_q.pop_front());
    if (r) begin
      fifo_q.delete();
      flight_q.delete();
      m_pc = RESET_PC;
    end else begin
      if (rdy && fifo_q.size() > 0 && !jmp) void'(fifo_q.pop_front());
      if (rv && flight_q.size() > 0) begin
        f = flight_q.pop_front();
        if (!f.stale && !jmp) fifo_q.push_back('{f.addr, mem_word(f.addr)});
      end
      if (jmp) begin
        fifo_q.delete();
        foreach (flight_q[i]) flight_q[i].stale = 1'b1;
        m_pc = {ja[31:2], 2'b00};
      end
      if (issue) begin
        flight_q.push_back('{m_pc, 1'b0});
        pend_q.push_back('{m_pc, cyc + dly});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    bit r;
    bit j;
    rst                 = 1'b1;
    jump_flag           = 1'b0;
    jump_addr           = '0;
    bus_if.mem_gnt_i    = 1'b0;
    bus_if.mem_rvalid_i = 1'b0;
    bus_if.mem_rdata_i  = '0;
    bus_if.ins_ready_i  = 1'b0;
    m_pc  = RESET_PC;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Streaming with full grant and single-cycle returns
    repeat (30) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Consumer stalled: requests stop at DEPTH credits, then drain in order
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Jump with returns still in flight
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 3);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    // Jump coinciding with a return and a pop, unaligned target
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 32'h0000_0202, 1'b1, 1'b1, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Address wrap at the top of memory
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 1'b1, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Back-to-back jumps
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b1, 2);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
    // Grant toggling with slow returns
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 32'h0, (i % 2) == 0, 1'b1, 3);
    // Reset with requests outstanding; late returns arrive during reset
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Fully random mix
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) < 2);
      j = ($urandom_range(0, 99) < 6);
      step(r, j, pick_jaddr(), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 70, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
